fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: two-entry circular instruction queue between fetch and decode.
// Each entry holds {pc, instr}. Outputs are decoded from registered state
// only, so a pushed entry reaches decode no earlier than the next cycle.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   pc_address_in    - PC of the incoming fetch
//   instr_in         - instruction word fetched at pc_address_in
//   in_valid         - incoming fetch is valid
//   in_ready         - queue can accept a push (count != 2)
//   flush            - redirect: drop every queued and incoming entry
//   dec_ready        - decode consumes the head entry
//   dec_valid        - head entry is valid
//   dec_pc           - head PC (0 when empty)
//   dec_pc_plus4     - dec_pc + 4, wrapping modulo 2^32
//   dec_instr        - head instruction (NOP_INSTR when empty)
//   count            - number of valid entries, 0..2
module fetch_queue #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_address_in,
    input  logic [31:0] instr_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4,
    output logic [31:0] dec_instr,
    output logic [1:0]  count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNTW  = 2;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc_mem_d    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] instr_mem_d [DEPTH];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            push;
    logic            pop;

    // Handshake qualifiers; flush overrides both.
    assign in_ready  = (count_q != CNTW'(2));
    assign dec_valid = (count_q != CNTW'(0));
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = dec_valid & dec_ready & ~flush;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (flush) begin
            // Stored data is left as-is; only the bookkeeping is cleared.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = CNTW'(0);
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = pc_address_in;
                instr_mem_d[wr_ptr_q] = instr_in;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= CNTW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; it is only observed when count != 0.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    // Head presentation; an empty queue shows a NOP at PC 0.
    always_comb begin
        dec_pc    = '0;
        dec_instr = NOP_INSTR;
        if (dec_valid) begin
            dec_pc    = pc_mem_q[rd_ptr_q];
            dec_instr = instr_mem_q[rd_ptr_q];
        end
    end

    assign dec_pc_plus4 = dec_pc + XLEN'(4);
    assign count        = count_q;

endmodule
